// File: rtl/rv_core_pkg.sv
// Core-wide constants shared by the fetch front end.
package rv_core_pkg;

  localparam int              XLEN     = 32;
  localparam int              ILEN     = 32;
  localparam logic [31:0]     RESET_PC = 32'h0000_0000;
  localparam int              PC_STEP  = 4;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO that holds fetched {instruction, pc} entries.
// flush empties it and takes priority over push and pop in the same cycle.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);
  import rv_core_pkg::*;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response queueing, redirect flush.
// Optional misaligned-redirect check is enabled by defining FETCH_MISALIGN_CHK_EN.
module instr_fetch_unit #(
  parameter int              XLEN     = rv_core_pkg::XLEN,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = rv_core_pkg::RESET_PC
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [XLEN-1:0]             imem_req_addr,
  input  logic                        imem_rsp_valid,
  input  logic [rv_core_pkg::ILEN-1:0] imem_rsp_data,
  output logic                        if_valid,
  input  logic                        if_ready,
  output logic [rv_core_pkg::ILEN-1:0] if_instr,
  output logic [XLEN-1:0]             if_pc,
  output logic                        fetch_fault
);
  import rv_core_pkg::*;

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ILEN + XLEN;

  logic [XLEN-1:0]    fetch_pc;
  logic [XLEN-1:0]    rsp_pc;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   drop;
  logic [CNT_W-1:0]   q_count;
  logic [CNT_W:0]     in_use;
  logic [XLEN-1:0]    redirect_target;
  logic               target_misaligned;
  logic               fault_q;
  logic               req_fire;
  logic               rsp_keep;
  logic               pop;
  logic [ENTRY_W-1:0] head_data;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redirect_target   = redirect_pc;
  assign target_misaligned = !is_word_aligned(redirect_pc[1:0]);

  // The fault is re-evaluated on every redirect, so an aligned redirect clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q <= target_misaligned;
    end
  end
`else
  logic unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign target_misaligned   = 1'b0;
  assign unused_redirect_lsb = ^{redirect_pc[1:0], target_misaligned};
  assign fault_q             = 1'b0;
`endif

  // A slot is reserved for every in-flight request, so the queue can never overflow.
  assign in_use         = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = !reset && !redirect_valid && !fault_q && (in_use < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign if_valid = !reset && (q_count != '0) && !redirect_valid;
  assign pop      = if_valid && if_ready;

  assign if_instr    = head_data[ENTRY_W-1:XLEN];
  assign if_pc       = head_data[XLEN-1:0];
  assign fetch_fault = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase

      // Everything still in flight at a redirect is stale, including a response landing now.
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        drop     <= outstanding - CNT_W'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        end
        if (imem_rsp_valid) begin
          if (drop != '0) begin
            drop <= drop - CNT_W'(1);
          end else begin
            rsp_pc <= rsp_pc + XLEN'(PC_STEP);
          end
        end
      end
    end
  end

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (pop),
    .head_data (head_data),
    .count     (q_count)
  );

endmodule
